// File: rtl/key_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// key_event_decoder_pkg
//   Shared definitions for consumers of the debounced key press/release flags.
//   Holds the gesture FSM state encoding, the default timing constants for a
//   50 MHz clock, and a small helper that identifies the "key held" states.
// -----------------------------------------------------------------------------
package key_event_decoder_pkg;

  // Gesture classifier states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } key_state_t;

  // Default terminal counts (cycles-1) at 50 MHz.
  localparam logic [31:0] DEF_LONG_CNT       = 32'd49_999_999; // 1 s
  localparam logic [31:0] DEF_DOUBLE_GAP_CNT = 32'd14_999_999; // 300 ms
  localparam logic [31:0] DEF_REPEAT_CNT     = 32'd4_999_999;  // 100 ms

  // True for the states in which the key is physically down.
  function automatic logic state_is_held(input key_state_t s);
    return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG_HOLD);
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//   Classifies debounced key gestures into single-cycle semantic events:
//   short click, double click, long press, and auto-repeat during long hold.
//
// Parameters
//   LONG_CNT        hold duration (cycles-1) before a press is long
//   DOUBLE_GAP_CNT  max released gap (cycles-1) for a double click
//   REPEAT_CNT      auto-repeat period (cycles-1) while in long hold
//
// Ports
//   Clk          in   clock
//   Reset_n      in   asynchronous active-low reset
//   Key_P_Flag   in   one-cycle debounced press pulse
//   Key_R_Flag   in   one-cycle debounced release pulse
//   Short_Flag   out  one-cycle pulse, single short click
//   Double_Flag  out  one-cycle pulse, double click
//   Long_Flag    out  one-cycle pulse, press held LONG_CNT+1 cycles
//   Repeat_Flag  out  one-cycle pulse every REPEAT_CNT+1 cycles in long hold
//   Key_Held     out  level, high in PRESS1 / PRESS2 / LONG_HOLD
// -----------------------------------------------------------------------------
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter logic [31:0] LONG_CNT       = DEF_LONG_CNT,
  parameter logic [31:0] DOUBLE_GAP_CNT = DEF_DOUBLE_GAP_CNT,
  parameter logic [31:0] REPEAT_CNT     = DEF_REPEAT_CNT
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Key_P_Flag,
  input  logic Key_R_Flag,
  output logic Short_Flag,
  output logic Double_Flag,
  output logic Long_Flag,
  output logic Repeat_Flag,
  output logic Key_Held
);

  key_state_t  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        short_nxt, double_nxt, long_nxt, repeat_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      Short_Flag  <= 1'b0;
      Double_Flag <= 1'b0;
      Long_Flag   <= 1'b0;
      Repeat_Flag <= 1'b0;
      Key_Held    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Short_Flag  <= short_nxt;
      Double_Flag <= double_nxt;
      Long_Flag   <= long_nxt;
      Repeat_Flag <= repeat_nxt;
      Key_Held    <= state_is_held(state_nxt);
    end
  end

  // Key flags are tested before the terminal count in every state, so a
  // relevant flag arriving on the terminal cycle wins over the timeout event.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (Key_P_Flag) begin
          state_nxt = ST_PRESS1;
        end
      end

      ST_PRESS1: begin
        if (Key_R_Flag) begin
          state_nxt = ST_WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_CNT) begin
          state_nxt = ST_LONG_HOLD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      ST_WAIT2: begin
        if (Key_P_Flag) begin
          state_nxt = ST_PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == DOUBLE_GAP_CNT) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      // Second press is never timed; only its release matters.
      ST_PRESS2: begin
        cnt_nxt = '0;
        if (Key_R_Flag) begin
          state_nxt  = ST_IDLE;
          double_nxt = 1'b1;
        end
      end

      ST_LONG_HOLD: begin
        if (Key_R_Flag) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_CNT) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
